// File: rtl/cpu_pkg.sv
// Shared pipeline-control types for the 5-stage CPU: operand-forward select
// encoding, hazard-controller modes and the shadow destination tag.
package cpu_pkg;

  localparam int RA_W = 5;

  typedef enum logic [1:0] {
    FWD_IDEX = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH,
    MODE_FREEZE
  } ctrl_mode_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } pipe_tag_t;

  localparam pipe_tag_t TAG_BUBBLE = '0;

  // Select the operand source for an instruction about to enter EX. ex_tag is
  // the producer that will sit in MEM after the edge, mem_tag the one that
  // will sit in WB. A load in ex_tag has no ALU result to offer, and the
  // younger producer always wins when both match.
  function automatic fwd_sel_t fwd_select(input logic [RA_W-1:0] src,
                                          input pipe_tag_t       ex_tag,
                                          input pipe_tag_t       mem_tag);
    fwd_sel_t sel;
    sel = FWD_IDEX;
    if (ex_tag.regwrite && !ex_tag.memread && (ex_tag.rd != '0) && (ex_tag.rd == src))
      sel = FWD_MEM;
    else if (mem_tag.regwrite && (mem_tag.rd != '0) && (mem_tag.rd == src))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Three-entry shadow of the destination/control tags held by the EX, MEM and
// WB stages. hold freezes every entry; bubble loads a NOP tag into EX.
module hazard_shadow_pipe
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hold,
  input  logic      bubble,
  input  pipe_tag_t id_tag,
  output pipe_tag_t ex_tag,
  output pipe_tag_t mem_tag,
  output pipe_tag_t wb_tag
);

  // Advance the tag pipeline one stage per unfrozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag  <= TAG_BUBBLE;
      mem_tag <= TAG_BUBBLE;
      wb_tag  <= TAG_BUBBLE;
    end else if (!hold) begin
      ex_tag  <= bubble ? TAG_BUBBLE : id_tag;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage CPU. Tracks EX/MEM/WB
// destination tags, registers the EX operand-forward selects and drives the
// PC / IF-ID / ID-EX / EX-MEM enables for freeze, flush and load-use stall.
module hazard_forward_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [CNT_W-1:0] stall_count
);

  import cpu_pkg::*;

  pipe_tag_t  id_tag;
  pipe_tag_t  ex_tag;
  pipe_tag_t  mem_tag;
  pipe_tag_t  wb_tag;
  ctrl_mode_t mode;
  logic       load_use;
  logic       shadow_hold;
  logic       shadow_bubble;
  fwd_sel_t   fwd_a_next;
  fwd_sel_t   fwd_b_next;
  logic       unused_wb;

  assign id_tag = '{rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  // The WB tag has no consumer yet; it stays in the shadow for completeness.
  assign unused_wb = ^wb_tag;

  assign shadow_hold   = (mode == MODE_FREEZE);
  assign shadow_bubble = (mode != MODE_RUN) || !id_valid;

  hazard_shadow_pipe u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (shadow_hold),
    .bubble  (shadow_bubble),
    .id_tag  (id_tag),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .wb_tag  (wb_tag)
  );

  // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
  always_comb begin
    load_use = id_valid && ex_tag.memread && ex_tag.regwrite && (ex_tag.rd != '0) &&
               ((ex_tag.rd == id_rs) || (id_uses_rt && (ex_tag.rd == id_rt)));
  end

  // Resolve the cycle's mode: memory freeze beats branch flush beats load-use stall.
  always_comb begin
    mode = MODE_RUN;
    if (dmem_busy)
      mode = MODE_FREEZE;
    else if (ex_branch_taken)
      mode = MODE_FLUSH;
    else if (load_use)
      mode = MODE_STALL;
  end

  // Pipeline enables for each mode.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    unique case (mode)
      MODE_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        exmem_hold = 1'b1;
      end
      MODE_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      MODE_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Forward selects for the instruction about to enter EX; bubbles need no forwarding.
  always_comb begin
    fwd_a_next = FWD_IDEX;
    fwd_b_next = FWD_IDEX;
    if (mode == MODE_RUN) begin
      fwd_a_next = fwd_select(id_rs, ex_tag, mem_tag);
      if (id_uses_rt)
        fwd_b_next = fwd_select(id_rt, ex_tag, mem_tag);
    end
  end

  // Register the selects so the EX muxes see no combinational path; hold them while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      forwardA <= FWD_IDEX;
      forwardB <= FWD_IDEX;
    end else if (mode != MODE_FREEZE) begin
      forwardA <= fwd_a_next;
      forwardB <= fwd_b_next;
    end
  end

  // Count every lost cycle, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if ((mode != MODE_RUN) && (stall_count != '1))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus a
// randomized run checked against an instruction-queue reference model.
module tb_hazard_forward_ctrl;

  localparam int RA_W    = 5;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int M_RUN    = 0;
  localparam int M_STALL  = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_FREEZE = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [RA_W-1:0]  id_rs = '0;
  logic [RA_W-1:0]  id_rt = '0;
  logic             id_uses_rt = 1'b0;
  logic [RA_W-1:0]  id_rd = '0;
  logic             id_regwrite = 1'b0;
  logic             id_memread = 1'b0;
  logic             ex_branch_taken = 1'b0;
  logic             dmem_busy = 1'b0;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_hold;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int passed = 0;

  // Reference model: instructions in flight, index 0 = in EX, 1 = in MEM, 2 = in WB.
  typedef struct {
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t     inflight[$];
  logic [1:0] exp_fa;
  logic [1:0] exp_fb;
  int         exp_cnt;

  hazard_forward_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .forwardA        (forwardA),
    .forwardB        (forwardB),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exmem_hold      (exmem_hold),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  // Reset the reference model to an empty pipeline.
  task automatic model_reset();
    instr_t nop;
    nop = '{rd: 0, rw: 1'b0, mr: 1'b0};
    inflight.delete();
    repeat (3) inflight.push_back(nop);
    exp_fa  = 2'b00;
    exp_fb  = 2'b00;
    exp_cnt = 0;
  endtask

  // Which mode the current inputs and in-flight instructions call for.
  function automatic int model_mode();
    bit hazard;
    hazard = id_valid && inflight[0].mr && inflight[0].rw && (inflight[0].rd != 0) &&
             ((inflight[0].rd == int'(id_rs)) || (id_uses_rt && (inflight[0].rd == int'(id_rt))));
    if (dmem_busy)            return M_FREEZE;
    else if (ex_branch_taken) return M_FLUSH;
    else if (hazard)          return M_STALL;
    return M_RUN;
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}.
  function automatic logic [4:0] model_ctrl();
    case (model_mode())
      M_FREEZE: return 5'b00001;
      M_FLUSH:  return 5'b11110;
      M_STALL:  return 5'b00010;
      default:  return 5'b11000;
    endcase
  endfunction

  // Source for a register read by the instruction entering EX: the nearest older
  // writer that can supply a value (a load still in EX cannot).
  function automatic logic [1:0] model_fwd(input int src);
    if (src == 0) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (inflight[k].rw && inflight[k].rd == src && !(k == 0 && inflight[k].mr))
        return (k == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  // Advance model and DUT across one rising edge; returns at edge + 1.
  task automatic step();
    int     m;
    instr_t nxt;
    m = model_mode();
    if (m != M_FREEZE) begin
      if (m == M_RUN) begin
        exp_fa = model_fwd(int'(id_rs));
        exp_fb = id_uses_rt ? model_fwd(int'(id_rt)) : 2'b00;
      end else begin
        exp_fa = 2'b00;
        exp_fb = 2'b00;
      end
      if (m == M_RUN && id_valid)
        nxt = '{rd: int'(id_rd), rw: id_regwrite, mr: id_memread};
      else
        nxt = '{rd: 0, rw: 1'b0, mr: 1'b0};
      inflight.push_front(nxt);
      void'(inflight.pop_back());
    end
    if (m != M_RUN && exp_cnt < CNT_MAX) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input bit v, input int rs, input int rt, input bit urt,
                          input int rd, input bit rw, input bit mr);
    id_valid    = v;
    id_rs       = RA_W'(rs);
    id_rt       = RA_W'(rt);
    id_uses_rt  = urt;
    id_rd       = RA_W'(rd);
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic idle_inputs();
    drive_id(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    ex_branch_taken = 1'b0;
    dmem_busy       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({forwardA, forwardB} !== 4'b0000)
      $display("[TB] FAIL reset_fwd got %b want 0000", {forwardA, forwardB});
    else passed++;
    checks++;
    if (stall_count !== '0)
      $display("[TB] FAIL reset_cnt got %0d want 0", stall_count);
    else passed++;
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold} !== 5'b11000)
      $display("[TB] FAIL reset_ctrl got %b want 11000",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold});
    else passed++;
  endtask

  task automatic test_forward_ex();
    do_reset();
    drive_id(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 3, 4, 1'b1, 6, 1'b1, 1'b0);
    #1;
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
      $display("[TB] FAIL fwd_ex_nostall got pc_write=%b bubble=%b want 1 0", pc_write, idex_bubble);
    else passed++;
    step();
    checks++;
    if (forwardA !== 2'b10 || forwardB !== 2'b00)
      $display("[TB] FAIL fwd_ex got A=%b B=%b want A=10 B=00", forwardA, forwardB);
    else passed++;
  endtask

  task automatic test_mem_priority();
    do_reset();
    drive_id(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 3, 3, 1'b1, 8, 1'b1, 1'b0);
    step();
    checks++;
    if (forwardA !== 2'b10 || forwardB !== 2'b10)
      $display("[TB] FAIL fwd_both got A=%b B=%b want A=10 B=10", forwardA, forwardB);
    else passed++;
    drive_id(1'b1, 0, 0, 1'b0, 4, 1'b1, 1'b0);
    step();
    drive_id(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 4, 7, 1'b0, 9, 1'b1, 1'b0);
    step();
    checks++;
    if (forwardA !== 2'b01 || forwardB !== 2'b00)
      $display("[TB] FAIL fwd_wb got A=%b B=%b want A=01 B=00", forwardA, forwardB);
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1'b1, 1, 2, 1'b1, 5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 1, 5, 1'b1, 7, 1'b1, 1'b0);
    #1;
    checks++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001)
      $display("[TB] FAIL lu_stall got %b want 001", {pc_write, ifid_write, idex_bubble});
    else passed++;
    step();
    checks++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b110)
      $display("[TB] FAIL lu_release got %b want 110", {pc_write, ifid_write, idex_bubble});
    else passed++;
    step();
    checks++;
    if (forwardB !== 2'b01 || forwardA !== 2'b00 || stall_count !== CNT_W'(1))
      $display("[TB] FAIL lu_fwd got A=%b B=%b cnt=%0d want A=00 B=01 cnt=1",
               forwardA, forwardB, stall_count);
    else passed++;
  endtask

  task automatic test_flush_priority();
    do_reset();
    drive_id(1'b1, 0, 0, 1'b0, 2, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5, 2, 1'b1, 6, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold} !== 5'b11110)
      $display("[TB] FAIL flush_ctrl got %b want 11110",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold});
    else passed++;
    step();
    ex_branch_taken = 1'b0;
    checks++;
    if (forwardA !== 2'b00 || forwardB !== 2'b00 || stall_count !== CNT_W'(1))
      $display("[TB] FAIL flush_fwd got A=%b B=%b cnt=%0d want 00 00 1", forwardA, forwardB, stall_count);
    else passed++;
  endtask

  task automatic test_freeze();
    do_reset();
    drive_id(1'b1, 0, 0, 1'b0, 5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 5, 0, 1'b0, 6, 1'b1, 1'b0);
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold} !== 5'b00001)
        $display("[TB] FAIL freeze_ctrl[%0d] got %b want 00001", i,
                 {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold});
      else passed++;
      step();
    end
    dmem_busy = 1'b0;
    #1;
    checks++;
    if ({pc_write, idex_bubble, exmem_hold} !== 3'b010)
      $display("[TB] FAIL freeze_then_stall got %b want 010", {pc_write, idex_bubble, exmem_hold});
    else passed++;
    step();
    checks++;
    if (stall_count !== CNT_W'(4))
      $display("[TB] FAIL freeze_cnt got %0d want 4", stall_count);
    else passed++;
    step();
    checks++;
    if (forwardA !== 2'b01)
      $display("[TB] FAIL freeze_fwd got %b want 01", forwardA);
    else passed++;
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive_id(1'b1, 0, 0, 1'b0, 0, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 0, 0, 1'b1, 4, 1'b1, 1'b0);
    #1;
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
      $display("[TB] FAIL r0_nostall got pc_write=%b bubble=%b want 1 0", pc_write, idex_bubble);
    else passed++;
    step();
    checks++;
    if (forwardA !== 2'b00 || forwardB !== 2'b00 || stall_count !== '0)
      $display("[TB] FAIL r0_fwd got A=%b B=%b cnt=%0d want 00 00 0", forwardA, forwardB, stall_count);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_busy = 1'b1;
    repeat (CNT_MAX + 3) step();
    dmem_busy = 1'b0;
    checks++;
    if (stall_count !== CNT_W'(CNT_MAX))
      $display("[TB] FAIL cnt_sat got %0d want %0d", stall_count, CNT_MAX);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_id(1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 3, 0, 1'b0, 5, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 9, 5, 1'b1, 6, 1'b1, 1'b0);
    dmem_busy = 1'b1;
    repeat (2) step();
    dmem_busy = 1'b0;
    #1;
    checks++;
    if (forwardA !== 2'b10 || stall_count !== CNT_W'(2) || idex_bubble !== 1'b1)
      $display("[TB] FAIL pre_reset got A=%b cnt=%0d bubble=%b want 10 2 1",
               forwardA, stall_count, idex_bubble);
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (forwardA !== 2'b00 || forwardB !== 2'b00 || stall_count !== '0)
      $display("[TB] FAIL async_reset_regs got A=%b B=%b cnt=%0d want 00 00 0",
               forwardA, forwardB, stall_count);
    else passed++;
    checks++;
    if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold} !== 5'b11000)
      $display("[TB] FAIL async_reset_ctrl got %b want 11000",
               {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold});
    else passed++;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [4:0] ec;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      drive_id($urandom_range(99) < 80, int'($urandom_range(3)), int'($urandom_range(3)),
               $urandom_range(1) == 1, int'($urandom_range(3)),
               $urandom_range(99) < 70, $urandom_range(99) < 35);
      ex_branch_taken = $urandom_range(99) < 10;
      dmem_busy       = $urandom_range(99) < 15;
      #1;
      ec = model_ctrl();
      checks++;
      if ({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold} !== ec)
        $display("[TB] FAIL rnd_ctrl[%0d] got %b want %b", n,
                 {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}, ec);
      else passed++;
      step();
      checks++;
      if (forwardA !== exp_fa || forwardB !== exp_fb)
        $display("[TB] FAIL rnd_fwd[%0d] got A=%b B=%b want A=%b B=%b", n,
                 forwardA, forwardB, exp_fa, exp_fb);
      else passed++;
      checks++;
      if (stall_count !== CNT_W'(exp_cnt))
        $display("[TB] FAIL rnd_cnt[%0d] got %0d want %0d", n, stall_count, exp_cnt);
      else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward_ex();
    test_mem_priority();
    test_load_use();
    test_flush_priority();
    test_freeze();
    test_reg_zero();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Keeps a shadow copy of the destination and control state for the EX, MEM and WB stages.
- Produces registered forwardA/forwardB selects for the EX-stage operand muxes, using the encoding 00=ID/EX, 01=WriteBackData, 10=MemAluOut, 11 never driven.
- Detects load-use hazards, branch flushes and data-memory wait, and drives PC/IF-ID/ID-EX/EX-MEM enables accordingly.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  RA_W  ID source register A.
- id_rt  in  RA_W  ID source register B.
- id_uses_rt  in  1  ID instruction reads rt as an operand.
- id_rd  in  RA_W  ID destination register.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- dmem_busy  in  1  data memory not ready; freeze the pipeline.
- forwardA  out  2  registered select for operand A mux.
- forwardB  out  2  registered select for operand B mux.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP controls into ID/EX.
- exmem_hold  out  1  hold EX/MEM and MEM/WB registers.
- stall_count  out  CNT_W  cycles lost to stall, flush or freeze (saturating).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - Shadow EX/MEM/WB entries cleared (rd=0, regwrite=0, memread=0).
  - forwardA=forwardB=00, stall_count=0.
  - Combinational outputs then evaluate to pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, exmem_hold=0.
- Load-use hazard (combinational), all of the following hold:
  - id_valid, ex_memread, ex_regwrite and ex_rd!=0;
  - ex_rd==id_rs, or (id_uses_rt and ex_rd==id_rt).
- Priority, highest first: FREEZE (dmem_busy) > FLUSH (ex_branch_taken) > STALL (load-use) > RUN.
- FREEZE:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=0, exmem_hold=1, ifid_flush=0.
  - All shadow registers and forwardA/forwardB hold.
  - A pending branch or hazard is re-evaluated once dmem_busy drops.
- FLUSH:
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Shadow EX receives a bubble; forwardA/forwardB load 00.
- STALL:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - Shadow EX receives a bubble; forwardA/forwardB load 00.
  - Exactly one bubble per load-use pair: next cycle the load is in MEM and no longer matches the hazard condition.
- RUN (also !id_valid):
  - Shadow EX loads the id_* fields; a bubble is loaded if !id_valid.
  - forwardA is computed against the state that will exist after the edge:
    - 10 if ex_regwrite && !ex_memread && ex_rd!=0 && ex_rd==id_rs;
    - else 01 if mem_regwrite && mem_rd!=0 && mem_rd==id_rs;
    - else 00.
  - forwardB: same rule with id_rt, and forced to 00 when !id_uses_rt.
  - MEM priority over WB is mandatory when both match.
- Non-freeze cycles: shadow WB<=MEM, MEM<=EX every cycle.
- Forward selects are registered: valid during the cycle the instruction occupies EX, zero combinational path to the muxes.
- stall_count increments by 1 in any non-RUN cycle and saturates at all-ones.
- Reset mid-stall or mid-freeze aborts immediately to reset values; no pending state survives.
- Register 0 never forwards and never triggers a hazard.

Decomposition:
- Shared package cpu_pkg holds:
  - fwd_sel_t encoding (FWD_IDEX=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10);
  - the RA_W constant;
  - the pipe_tag_t struct {rd, regwrite, memread}.
- One natural sub-module: hazard_shadow_pipe, the 3-entry shadow tag pipeline with hold/bubble inputs.
- Forward and hazard comparison logic stays in the top module.

Test Plan:
- add r3 in EX (regwrite) then ID reads rs=3 -> next cycle forwardA=10, forwardB=00, no stall.
- r3 written by both EX-stage and MEM-stage producers, consumer rs=3 -> forwardA=10 (MEM wins); with only the MEM-stage producer -> 01.
- lw r5 in EX, ID rt=5 with id_uses_rt=1:
  - first cycle pc_write=0, ifid_write=0, idex_bubble=1;
  - next cycle RUN, then forwardB=01; stall_count=1.
- ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_write=1 (flush wins); forwardA/B=00.
- dmem_busy=1 for 3 cycles during a load-use hazard:
  - pc_write=0 and exmem_hold=1 throughout, shadow frozen;
  - after release, one STALL cycle; stall_count=4.
- rd=0 producer matching rs=0 -> forwardA=00, no stall; assert rst_n=0 mid-stall -> all outputs return to reset values asynchronously.
